ezm_progstore: RTL

Program store and sequencer that sits directly upstream of the ezm accumulator CPU. It holds a 6-bit instruction memory that is filled over a valid/ready load port. During run it decodes the CPU's time-multiplexed 8-bit output: the pc on fetch cycles and the accumulator on execute cycles. It drives the CPU's instruction input so that each word is valid through both the fetch and execute cycles, and it controls the CPU reset so a loaded program always starts from pc 0.

---
 rtl/ezm_progstore.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ezm_progstore.sv
// Program store and fetch/execute sequencer for the ezm accumulator CPU.
// Loads 6-bit words over a valid/ready port and feeds them to the CPU with a held instruction register.
module ezm_progstore #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ld_start,
   input  logic       ld_valid,
   input  logic [5:0] ld_data,
   input  logic       ld_last,
   output logic       ld_ready,
   input  logic       go,
   input  logic [7:0] cpu_out,
   output logic [5:0] cpu_in,
   output logic       cpu_rst,
   output logic       running,
   output logic [7:0] pc_o,
   output logic [7:0] acc_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   logic [1:0]    state_r;
   logic [AW-1:0] wr_addr_r;
   logic          phase_r;
   logic [5:0]    ir_r;
   logic [7:0]    pc_r;
   logic [7:0]    acc_r;
   logic [5:0]    mem_r [DEPTH];

   logic [5:0]    fetch_word_s;
   logic          wr_en_s;
   logic          ld_end_s;

   // Upper pc bits are dropped so the program wraps modulo DEPTH.
   assign fetch_word_s = mem_r[cpu_out[AW-1:0]];
   assign wr_en_s      = (state_r == ST_LOAD) && ld_valid && !ld_start;
   assign ld_end_s     = ld_last || (wr_addr_r == AW'(DEPTH - 1));

   // Sequencer state and load write pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         wr_addr_r <= {AW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ld_start) begin
                  state_r   <= ST_LOAD;
                  wr_addr_r <= {AW{1'b0}};
               end else if (go) begin
                  state_r <= ST_RUN;
               end
            end
            ST_LOAD: begin
               if (ld_start) begin
                  wr_addr_r <= {AW{1'b0}};
               end else if (ld_valid) begin
                  // The pointer parks on the last word written so it can never wrap.
                  if (ld_end_s) begin
                     state_r <= ST_IDLE;
                  end else begin
                     wr_addr_r <= wr_addr_r + AW'(1);
                  end
               end
            end
            ST_RUN: begin
               if (ld_start) begin
                  state_r   <= ST_LOAD;
                  wr_addr_r <= {AW{1'b0}};
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               wr_addr_r <= {AW{1'b0}};
            end
         endcase
      end
   end

   // Fetch/execute phase, held instruction and CPU output monitors.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_r <= 1'b0;
         ir_r    <= 6'd0;
         pc_r    <= 8'd0;
         acc_r   <= 8'd0;
      end else if (state_r == ST_RUN) begin
         phase_r <= ~phase_r;
         if (!phase_r) begin
            ir_r <= fetch_word_s;
            pc_r <= cpu_out;
         end else begin
            acc_r <= cpu_out;
         end
      end else begin
         phase_r <= 1'b0;
      end
   end

   // Instruction memory; reset fills it with no-op words.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 6'd0;
         end
      end else if (wr_en_s) begin
         mem_r[wr_addr_r] <= ld_data;
      end
   end

   // Instruction must stay valid across both halves of each CPU instruction.
   always_comb begin
      cpu_in = 6'd0;
      if (state_r == ST_RUN) begin
         cpu_in = phase_r ? ir_r : fetch_word_s;
      end else begin
         cpu_in = 6'd0;
      end
   end

   assign cpu_rst  = (state_r != ST_RUN);
   assign ld_ready = (state_r == ST_LOAD);
   assign running  = (state_r == ST_RUN);
   assign pc_o     = pc_r;
   assign acc_o    = acc_r;

endmodule
